// File: rtl/enc_filter.sv
// enc_filter: input conditioning and quadrature decode for one rotary encoder.
//
// Each raw channel passes through a two-flop synchronizer and an independent
// debounce filter; the clean pair is then decoded as a Gray-code sequence.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   a_raw      raw channel A pin (asynchronous, idle high)
//   b_raw      raw channel B pin (asynchronous, idle high)
//   a_clean    debounced channel A
//   b_clean    debounced channel B
//   cw         one-cycle pulse per clockwise step   (AB 11->01->00->10->11)
//   ccw        one-cycle pulse per counter-clockwise step
//   err        one-cycle pulse when both clean bits change in the same cycle
//   err_count  saturating count of err pulses
module enc_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500,
    parameter int unsigned ERR_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_raw,
    input  logic             b_raw,
    output logic             a_clean,
    output logic             b_clean,
    output logic             cw,
    output logic             ccw,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [15:0] TERM = 16'(DEBOUNCE_CYCLES - 1);

    // Channel index 1 = A, 0 = B throughout.
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  clean;
    logic [15:0] cnt [2];
    logic [1:0]  prev;

    logic        cw_next;
    logic        ccw_next;
    logic        err_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {a_raw, b_raw};
            sync2 <= sync1;
        end
    end

    // The clean value only moves after the synchronized level has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clean <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    clean[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign a_clean = clean[1];
    assign b_clean = clean[0];

    // Transition prev -> clean; at most one of the three flags is ever set.
    always_comb begin
        cw_next  = 1'b0;
        ccw_next = 1'b0;
        err_next = 1'b0;
        if ((prev ^ clean) == 2'b11) begin
            err_next = 1'b1;
        end else begin
            unique case ({prev, clean})
                4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: cw_next  = 1'b1;
                4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: ccw_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev      <= 2'b11;
            cw        <= 1'b0;
            ccw       <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            prev <= clean;
            cw   <= cw_next;
            ccw  <= ccw_next;
            err  <= err_next;
            if (err_next && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enc_filter.sv
// Directed testbench for enc_filter with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_enc_filter;

    logic       clk;
    logic       reset_n;
    logic       a_raw;
    logic       b_raw;
    logic       a_clean;
    logic       b_clean;
    logic       cw;
    logic       ccw;
    logic       err;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse/level accumulators updated on every tick.
    int n_cw    = 0;
    int n_ccw   = 0;
    int n_err   = 0;
    int n_excl  = 0;
    int n_a_low = 0;

    enc_filter #(
        .DEBOUNCE_CYCLES(4),
        .ERR_W          (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_raw    (a_raw),
        .b_raw    (b_raw),
        .a_clean  (a_clean),
        .b_clean  (b_clean),
        .cw       (cw),
        .ccw      (ccw),
        .err      (err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if ((int'(cw) + int'(ccw) + int'(err)) > 1) n_excl++;
        n_cw  += int'(cw);
        n_ccw += int'(ccw);
        n_err += int'(err);
        if (!a_clean) n_a_low++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_cw    = 0;
        n_ccw   = 0;
        n_err   = 0;
        n_a_low = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset with inputs low ----------------
        reset_n = 1'b0;
        a_raw   = 1'b0;
        b_raw   = 1'b0;
        step(3);
        chk("rst_a_clean", 32'(a_clean), 1);
        chk("rst_b_clean", 32'(b_clean), 1);
        chk("rst_cw", 32'(cw), 0);
        chk("rst_ccw", 32'(ccw), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_count", 32'(err_count), 0);

        reset_n = 1'b1;
        step(5);
        chk("rel_a_hold_5", 32'(a_clean), 1);
        chk("rel_b_hold_5", 32'(b_clean), 1);
        tick();
        chk("rel_a_fall_6", 32'(a_clean), 0);
        chk("rel_b_fall_6", 32'(b_clean), 0);
        chk("rel_err_early", 32'(err), 0);
        tick();
        chk("rel_err_pulse", 32'(err), 1);
        chk("rel_err_count1", 32'(err_count), 1);
        chk("rel_no_cw", 32'(cw), 0);
        tick();
        chk("rel_err_one_cycle", 32'(err), 0);

        // Back to 11 idle (00 -> 11 is another illegal step, err_count -> 2).
        a_raw = 1'b1;
        b_raw = 1'b1;
        step(12);
        chk("idle_err_count2", 32'(err_count), 2);

        // ---------------- clean CW cycle ----------------
        clear_counts();
        a_raw = 1'b0;
        step(5);
        chk("cw_a_hold_5", 32'(a_clean), 1);
        tick();
        chk("cw_a_fall_6", 32'(a_clean), 0);
        chk("cw_not_yet", 32'(cw), 0);
        tick();
        chk("cw_pulse", 32'(cw), 1);
        chk("cw_no_ccw", 32'(ccw), 0);
        tick();
        chk("cw_one_cycle", 32'(cw), 0);
        b_raw = 1'b0; step(10);
        a_raw = 1'b1; step(10);
        b_raw = 1'b1; step(10);
        chk("cw_total", 32'(n_cw), 4);
        chk("cw_total_ccw", 32'(n_ccw), 0);
        chk("cw_total_err", 32'(n_err), 0);

        // ---------------- CCW cycle 11->10->00->01->11 ----------------
        clear_counts();
        b_raw = 1'b0; step(10);
        a_raw = 1'b0; step(10);
        b_raw = 1'b1; step(10);
        a_raw = 1'b1; step(10);
        chk("ccw_total", 32'(n_ccw), 4);
        chk("ccw_total_cw", 32'(n_cw), 0);
        chk("ccw_total_err", 32'(n_err), 0);
        chk("ccw_end_ab", 32'({a_clean, b_clean}), 3);

        // ---------------- bounce rejection ----------------
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            a_raw = 1'b0; tick();
            a_raw = 1'b1; tick();
        end
        step(10);
        a_raw = 1'b0; step(3);
        a_raw = 1'b1; step(10);
        chk("bounce_a_low_cycles", 32'(n_a_low), 0);
        chk("bounce_pulses", 32'(n_cw + n_ccw + n_err), 0);
        a_raw = 1'b0; step(10);
        chk("bounce_a_settled", 32'(a_clean), 0);
        chk("bounce_cw", 32'(n_cw), 1);
        chk("bounce_ccw", 32'(n_ccw), 0);

        // 01 -> 11 to return to idle.
        a_raw = 1'b1; step(10);

        // ---------------- illegal transitions / saturation ----------------
        clear_counts();
        for (int i = 1; i <= 300; i++) begin
            a_raw = (i % 2 == 0);
            b_raw = (i % 2 == 0);
            step(8);
        end
        chk("ill_err_pulses", 32'(n_err), 300);
        chk("ill_cw", 32'(n_cw), 0);
        chk("ill_ccw", 32'(n_ccw), 0);
        chk("ill_err_count_sat", 32'(err_count), 255);
        step(10);
        chk("ill_err_count_hold", 32'(err_count), 255);

        // ---------------- reset mid-debounce ----------------
        clear_counts();
        a_raw = 1'b0;
        step(4);                 // filter count now 2
        reset_n = 1'b0;
        tick();
        chk("mid_rst_a_clean", 32'(a_clean), 1);
        chk("mid_rst_err_count", 32'(err_count), 0);
        reset_n = 1'b1;
        step(5);
        chk("mid_no_early_change", 32'(n_a_low), 0);
        tick();
        chk("mid_a_fall_6", 32'(a_clean), 0);
        step(3);
        chk("mid_cw", 32'(n_cw), 1);
        chk("mid_err", 32'(n_err), 0);

        chk("mutual_exclusion", 32'(n_excl), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
